// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Write-back store queue between the MEM stage and the data memory. Word
// stores are queued in an in-order circular FIFO and drained one per cycle
// into the data memory's single shared address port.
//
// Port arbitration:
//   - A load normally owns the port.
//   - The buffer writes its head entry on any cycle without a load.
//   - If loads have blocked draining for STARVE_LIMIT consecutive cycles, the
//     buffer takes the port and the load is stalled (ld_stall) for one cycle.
//
// Loads whose word address matches a queued entry see that entry's data on
// fwd_data. If several entries match, the youngest one is returned.
//
// Handshake: a store transfers on a rising edge where st_valid && st_ready.
// st_ready depends only on the occupancy. A full buffer refuses a store even
// on a cycle where it also drains.
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   st_valid/st_pc/st_addr/st_data/st_ready   store enqueue side
//   ld_valid/ld_addr      load lookup and port request
//   ld_stall              load must repeat next cycle (forced drain)
//   fwd_hit/fwd_data      forwarding result for ld_addr
//   empty                 no entries queued
//   dm_we/dm_pc/dm_addr/dm_wdata  shared data memory port
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_pc,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_stall,
    output logic        fwd_hit,
    output logic [31:0] fwd_data,
    output logic        empty,
    output logic        dm_we,
    output logic [31:0] dm_pc,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    // Entry storage. The payload is not reset; only the valid bits are.
    logic [31:0]      ent_pc   [DEPTH];
    logic [29:0]      ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [DEPTH-1:0] ent_valid;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [STV_W-1:0] starve;

    logic             force_drain;
    logic             drain;
    logic             push;
    logic [PTR_W-1:0] fwd_idx;

    assign empty       = (count == '0);
    assign st_ready    = (count != CNT_W'(DEPTH));
    assign force_drain = (starve == STV_W'(STARVE_LIMIT)) && !empty;
    assign drain       = !empty && (!ld_valid || force_drain);
    assign push        = st_valid && st_ready;

    assign ld_stall = ld_valid && force_drain;
    assign dm_we    = drain;
    assign dm_addr  = drain ? {ent_addr[head], 2'b00} : ld_addr;
    assign dm_pc    = drain ? ent_pc[head]   : 32'h0;
    assign dm_wdata = drain ? ent_data[head] : 32'h0;

    // Walk entries oldest to youngest so that the last match wins, giving the
    // youngest matching store. The entry draining this cycle is still valid.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 32'h0;
        fwd_idx  = head;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PTR_W'(i);
            if (ent_valid[fwd_idx] && (ent_addr[fwd_idx] == ld_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data[fwd_idx];
            end
        end
    end

    // Control state: pointers, occupancy, valid bits and the starve counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            starve    <= '0;
            ent_valid <= '0;
        end else begin
            // The push and pop slots never coincide. An empty buffer cannot pop
            // and a full buffer cannot push.
            if (push) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + PTR_W'(1);
            end
            if (drain) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_W'(1);
            end

            case ({push, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // A forced drain is also a drain, so the counter clears on that
            // cycle and then starts counting again.
            if (drain || empty) begin
                starve <= '0;
            end else if (ld_valid && (starve != STV_W'(STARVE_LIMIT))) begin
                starve <= starve + STV_W'(1);
            end
        end
    end

    // Payload write. The address is held as a word address.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_pc[tail]   <= st_pc;
            ent_addr[tail] <= st_addr[31:2];
            ent_data[tail] <= st_data;
        end
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
Write-back store queue between the MEM pipeline stage and the data memory. It accepts word stores from MEM, holds them in a small in-order FIFO, and drains one entry per cycle into the data memory's single shared address port. Loads get priority on that port. Loads that hit a queued store are forwarded from the buffer. A starvation counter forces a drain if loads monopolise the port.

Parameters:
DEPTH, 4, number of queued stores (power of two, ≥2)
STARVE_LIMIT, 8, consecutive blocked-drain cycles before a forced drain

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
st_valid  input  1  MEM stage presents a store this cycle
st_pc  input  32  PC of the store instruction
st_addr  input  32  store byte address (bits [1:0] ignored)
st_data  input  32  store word
st_ready  output  1  buffer can accept a store this cycle (not full)
ld_valid  input  1  MEM stage performs a load this cycle
ld_addr  input  32  load byte address
ld_stall  output  1  load must hold; forced drain owns the port
fwd_hit  output  1  ld_addr matches a queued entry
fwd_data  output  32  data of the youngest matching entry
empty  output  1  no entries queued (fence / syscall drain check)
dm_we  output  1  write enable to data memory
dm_pc  output  32  PC of the draining store, for the memory's write log
dm_addr  output  32  address to data memory: load address or head address
dm_wdata  output  32  write data to data memory

Behaviour:
- Reset (reset=0, asynchronous):
  - head, tail, count and starve counter cleared; all entries invalid.
  - Outputs: st_ready=1, empty=1, dm_we=0, ld_stall=0, fwd_hit=0, fwd_data=0.
  - Reset mid-operation discards queued stores; they never reach memory.
- Enqueue: on a rising edge with st_valid=1 and st_ready=1, write {st_pc, st_addr[31:2], st_data} at tail; tail++ modulo DEPTH.
- st_ready = (count != DEPTH). A full buffer does not accept even if draining in the same cycle (no bypass).
- Port arbitration (combinational, per cycle):
  - force = (starve == STARVE_LIMIT) && !empty.
  - If ld_valid && !force: dm_addr=ld_addr, dm_we=0.
  - Else if !empty: dm_addr={head.addr,2'b00}, dm_pc=head.pc, dm_wdata=head.data, dm_we=1. On the edge, pop: head++ modulo DEPTH.
  - Else: dm_we=0, dm_addr=ld_addr.
- ld_stall = ld_valid && force. The load repeats next cycle.
- Starve counter:
  - Increments on cycles with ld_valid && !empty && !force, saturating at STARVE_LIMIT.
  - Clears on any cycle a drain occurs, or when empty.
- Latency: a store accepted at edge N is presented to memory no earlier than the cycle after edge N and is written at edge N+1 at the earliest.
- Simultaneous push and pop: count is unchanged. With count=1, the head drains while the new entry lands in the next slot.
- Forwarding:
  - Compare ld_addr[31:2] with every valid entry. fwd_hit=1 if any matches; fwd_data = youngest match (closest to tail).
  - The entry currently draining still counts as valid this cycle.
  - A store arriving in the same cycle (st_valid) is not visible to a load in that cycle.
- st_valid and ld_valid are mutually exclusive by pipeline construction. If both are seen, both are processed as specified above.
- Stores are drained strictly in order; order is preserved across wrap-around of head and tail.
- empty = (count==0).

Test Plan:
- Reset, then three stores to 0x10, 0x14, 0x18 (data 1, 2, 3), no loads -> dm_we pulses on three consecutive cycles in order; empty=1 afterwards; st_ready held at 1.
- Five stores back-to-back with ld_valid held at 1 -> 5th store sees st_ready=0. After 8 blocked cycles, ld_stall=1 for one cycle and the head entry (0x10, data 1) is written.
- Stores 0x20←0xAA then 0x20←0xBB queued, load 0x22 -> fwd_hit=1, fwd_data=0xBB. Load 0x24 -> fwd_hit=0.
- Fill to DEPTH, drain while enqueueing 8 further stores -> all 12 writes reach memory in issue order across pointer wrap; count never exceeds 4.
- Reset asserted asynchronously with 3 entries queued, mid-cycle -> dm_we drops immediately, empty=1, no further writes after release.
- Load to an empty buffer -> dm_addr=ld_addr, dm_we=0, fwd_hit=0, ld_stall=0.
